// File: rtl/instr_mem_loader_if.sv
// Word stream and byte write port of the instruction memory loader.
// Handshake: a word transfers on the rising edge where i_word_valid and o_word_ready are both 1;
// the producer keeps i_word/i_last stable while i_word_valid=1 and o_word_ready=0.
interface instr_mem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              i_word_valid;
    logic [31:0]       i_word;
    logic              i_last;
    logic              o_word_ready;
    logic              o_we;
    logic [ADDR_W-1:0] o_waddr;
    logic [7:0]        o_wdata;

    modport master (
        output i_word_valid, i_word, i_last,
        input  o_word_ready, o_we, o_waddr, o_wdata
    );

    modport slave (
        input  i_word_valid, i_word, i_last,
        output o_word_ready, o_we, o_waddr, o_wdata
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Splits 32-bit instruction words into four little-endian byte writes at consecutive addresses.
// Optional running word checksum output enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base_addr,
    instr_mem_loader_if.slave bus,
    output logic              o_busy,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err,
`ifdef LOADER_CHECKSUM_EN
    output logic [31:0]       o_checksum,
`endif
    output logic [2:0]        o_dbg_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ACCEPT = 3'd1;
    localparam logic [2:0] S_WR0    = 3'd2;
    localparam logic [2:0] S_WR1    = 3'd3;
    localparam logic [2:0] S_WR2    = 3'd4;
    localparam logic [2:0] S_WR3    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERR    = 3'd7;

    // Highest base for which all four bytes of a word still fit in memory.
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH - 4);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       word_q, word_d;
    logic              last_q, last_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       cks_q, cks_d;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        last_d  = last_q;
`ifdef LOADER_CHECKSUM_EN
        cks_d   = cks_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (i_start) begin
                    addr_d  = i_base_addr;
                    state_d = S_ACCEPT;
`ifdef LOADER_CHECKSUM_EN
                    cks_d   = 32'd0;
`endif
                end
            end
            S_ACCEPT: begin
                if (bus.i_word_valid) begin
                    word_d = bus.i_word;
                    last_d = bus.i_last;
                    if (addr_q > ADDR_LIMIT) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_WR0;
`ifdef LOADER_CHECKSUM_EN
                        cks_d   = cks_q + bus.i_word;
`endif
                    end
                end
            end
            S_WR0: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_WR1;
            end
            S_WR1: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_WR2;
            end
            S_WR2: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = S_WR3;
            end
            S_WR3: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = last_q ? S_DONE : S_ACCEPT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every port comes straight from a flop;
    // in a write state addr_d is exactly the byte address of that write.
    always_comb begin
        ready_d = (state_d == S_ACCEPT);
        we_d    = (state_d >= S_WR0) && (state_d <= S_WR3);
        busy_d  = ready_d || we_d;
        done_d  = (state_d == S_DONE);
        err_d   = (state_d == S_ERR);
        waddr_d = we_d ? addr_d : '0;
        case (state_d)
            S_WR0:   wdata_d = word_d[7:0];
            S_WR1:   wdata_d = word_d[15:8];
            S_WR2:   wdata_d = word_d[23:16];
            S_WR3:   wdata_d = word_d[31:24];
            default: wdata_d = 8'd0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            word_q  <= 32'd0;
            last_q  <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            cks_q   <= cks_d;
`endif
        end
    end

    assign bus.o_word_ready = ready_q;
    assign bus.o_we         = we_q;
    assign bus.o_waddr      = waddr_q;
    assign bus.o_wdata      = wdata_q;
    assign o_busy           = busy_q;
    assign o_cpu_hold       = busy_q;
    assign o_done           = done_q;
    assign o_err            = err_q;
    assign o_dbg_state      = state_q;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum       = cks_q;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: byte write log checked against expected writes per scenario.
module tb_instr_mem_loader;
    localparam int ADDR_W    = 32;
    localparam int MEM_DEPTH = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ACCEPT = 3'd1;
    localparam logic [2:0] ST_WR1    = 3'd3;
    localparam logic [2:0] ST_WR2    = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic              busy, hold, done, err;
    logic [2:0]        dbg;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]       cks;
`endif

    instr_mem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_mem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .bus         (bus),
        .o_busy      (busy),
        .o_cpu_hold  (hold),
        .o_done      (done),
        .o_err       (err),
`ifdef LOADER_CHECKSUM_EN
        .o_checksum  (cks),
`endif
        .o_dbg_state (dbg)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [39:0] exp_q[$];
    logic [39:0] act_q[$];

    // Write monitor: records {address, byte} for every enabled write edge.
    always @(posedge clk) begin
        cyc++;
        if (bus.o_we === 1'b1) act_q.push_back({bus.o_waddr, bus.o_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [31:0] b);
        start = 1'b1;
        base  = b;
        tick();
        start = 1'b0;
    endtask

    task automatic exp_word(input logic [31:0] a, input logic [31:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back({a + 32'(k), w[8*k +: 8]});
    endtask

    task automatic send_word(input logic [31:0] w, input logic l);
        int n;
        n = 0;
        bus.i_word_valid = 1'b1;
        bus.i_word       = w;
        bus.i_last       = l;
        while (bus.o_word_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            total++; bad++;
            $display("FAIL ready_timeout: o_word_ready=%b required 1 within 40 cycles", bus.o_word_ready);
        end
        tick();
        bus.i_word_valid = 1'b0;
    endtask

    task automatic wait_end(output int n);
        n = 0;
        while (!(done === 1'b1 || err === 1'b1) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            total++; bad++;
            $display("FAIL end_timeout: done=%b err=%b required one of them within 60 cycles", done, err);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        total++;
        if ({bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_word_ready, busy, hold, done, err, dbg} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: we=%b waddr=%h wdata=%h rdy=%b busy=%b hold=%b done=%b err=%b st=%0d required all 0",
                     bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_word_ready, busy, hold, done, err, dbg);
        end
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (dbg !== ST_IDLE || bus.o_word_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: st=%0d rdy=%b required st=0 rdy=0", dbg, bus.o_word_ready);
        end
    endtask

    task automatic test_basic();
        int s, n;
        act_q.delete(); exp_q.delete();
        start_load(32'h64);
        s = cyc;
        total++;
        if (bus.o_word_ready !== 1'b1 || dbg !== ST_ACCEPT) begin
            bad++;
            $display("FAIL start_latency: rdy=%b st=%0d required rdy=1 st=1", bus.o_word_ready, dbg);
        end
        exp_word(32'h64, 32'h00500093);
        exp_word(32'h68, 32'h00a00113);
        exp_word(32'h6C, 32'h002081b3);
        send_word(32'h00500093, 1'b0);
        total++;
        if (bus.o_we !== 1'b1 || bus.o_waddr !== 32'h64 || bus.o_wdata !== 8'h93) begin
            bad++;
            $display("FAIL first_write: we=%b addr=%h data=%h required 1 00000064 93", bus.o_we, bus.o_waddr, bus.o_wdata);
        end
        total++;
        if (busy !== 1'b1 || hold !== 1'b1 || bus.o_word_ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_during_load: busy=%b hold=%b rdy=%b required 1 1 0", busy, hold, bus.o_word_ready);
        end
        send_word(32'h00a00113, 1'b0);
        send_word(32'h002081b3, 1'b1);
        wait_end(n);
        total++;
        if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || hold !== 1'b0) begin
            bad++;
            $display("FAIL basic_done: done=%b err=%b busy=%b hold=%b required 1 0 0 0", done, err, busy, hold);
        end
        total++;
        if (cyc - s !== 15) begin
            bad++;
            $display("FAIL busy_fall_cycles: got %0d required 15", cyc - s);
        end
`ifdef LOADER_CHECKSUM_EN
        total++;
        if (cks !== 32'h00500093 + 32'h00a00113 + 32'h002081b3) begin
            bad++;
            $display("FAIL checksum: got %h required %h", cks, 32'h00500093 + 32'h00a00113 + 32'h002081b3);
        end
`endif
        total++;
        if (act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL basic_write_count: got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        int n;
        act_q.delete(); exp_q.delete();
        start_load(32'h20);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (bus.o_word_ready !== 1'b1 || bus.o_we !== 1'b0 || dbg !== ST_ACCEPT) begin
                bad++;
                $display("FAIL stall_c%0d: rdy=%b we=%b st=%0d required 1 0 1", i, bus.o_word_ready, bus.o_we, dbg);
            end
            tick();
        end
        exp_word(32'h20, 32'h01020304);
        send_word(32'h01020304, 1'b1);
        wait_end(n);
        total++;
        if (act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL stall_write_count: got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL stall_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_boundary();
        int n;
        act_q.delete(); exp_q.delete();
        start_load(32'hFC);
        exp_word(32'hFC, 32'hDEADBEEF);
        send_word(32'hDEADBEEF, 1'b1);
        wait_end(n);
        total++;
        if (done !== 1'b1 || err !== 1'b0) begin
            bad++;
            $display("FAIL top_word_done: done=%b err=%b required 1 0", done, err);
        end
        total++;
        if (act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL top_write_count: got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL top_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
        act_q.delete(); exp_q.delete();
        start_load(32'hFD);
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL done_cleared_on_start: done=%b required 0", done);
        end
        send_word(32'h12345678, 1'b1);
        total++;
        if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || bus.o_we !== 1'b0 || dbg !== ST_ERR) begin
            bad++;
            $display("FAIL range_err: err=%b done=%b busy=%b we=%b st=%0d required 1 0 0 0 7", err, done, busy, bus.o_we, dbg);
        end
        tick(); tick(); tick();
        total++;
        if (act_q.size() !== 0 || err !== 1'b1) begin
            bad++;
            $display("FAIL range_no_writes: writes=%0d err=%b required 0 1", act_q.size(), err);
        end
    endtask

    task automatic test_reset_mid_load();
        int n;
        act_q.delete(); exp_q.delete();
        start_load(32'h10);
        send_word(32'h11223344, 1'b0);
        send_word(32'h55667788, 1'b0);
        tick(); tick();
        total++;
        if (dbg !== ST_WR2) begin
            bad++;
            $display("FAIL reach_wr2: st=%0d required 4", dbg);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_word_ready, busy, hold, done, err, dbg} !== '0) begin
            bad++;
            $display("FAIL async_reset: we=%b waddr=%h wdata=%h rdy=%b busy=%b hold=%b done=%b err=%b st=%0d required all 0",
                     bus.o_we, bus.o_waddr, bus.o_wdata, bus.o_word_ready, busy, hold, done, err, dbg);
        end
        exp_word(32'h10, 32'h11223344);
        exp_q.push_back({32'h14, 8'h88});
        exp_q.push_back({32'h15, 8'h77});
        tick();
        rst = 1'b0;
        tick();
        total++;
        if (act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL partial_write_count: got %0d required %0d", act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL partial_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
        act_q.delete(); exp_q.delete();
        start_load(32'h10);
        exp_word(32'h10, 32'hCAFEF00D);
        send_word(32'hCAFEF00D, 1'b1);
        wait_end(n);
        total++;
        if (done !== 1'b1 || act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL reload_after_reset: done=%b writes=%0d required 1 %0d", done, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL reload_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_start_ignored();
        int n;
        act_q.delete(); exp_q.delete();
        start_load(32'h40);
        exp_word(32'h40, 32'hA1A2A3A4);
        exp_word(32'h44, 32'hB1B2B3B4);
        send_word(32'hA1A2A3A4, 1'b0);
        tick();
        total++;
        if (dbg !== ST_WR1) begin
            bad++;
            $display("FAIL reach_wr1: st=%0d required 3", dbg);
        end
        start = 1'b1;
        base  = 32'h80;
        tick();
        start = 1'b0;
        send_word(32'hB1B2B3B4, 1'b1);
        wait_end(n);
        total++;
        if (done !== 1'b1 || act_q.size() !== exp_q.size()) begin
            bad++;
            $display("FAIL start_ignored_done: done=%b writes=%0d required 1 %0d", done, act_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            total++;
            if (act_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL start_ignored_wr%0d: got %h required %h", i, act_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        start            = 1'b0;
        base             = '0;
        bus.i_word_valid = 1'b0;
        bus.i_word       = 32'd0;
        bus.i_last       = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_boundary();
        test_reset_mid_load();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
